// File: rtl/rcvr_pkg.sv
// -----------------------------------------------------------------------------
// rcvr_pkg
// Shared definitions for the RX_PATH receive sequencer (rcvr_seq_fsm).
//   - rcvr_state_e : sequencer states, 2-bit encoding
//   - RCVR_*       : default data width, bytes-per-beat and DLP timeout/retry
//   - beat_bytes() : bytes delivered by one rx beat for a given bus width/mode
// -----------------------------------------------------------------------------
package rcvr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DUMMY   = 2'd1,
    ST_DLP     = 2'd2,
    ST_RD_DATA = 2'd3
  } rcvr_state_e;

  localparam int RCVR_DATA_W    = 8;
  localparam int RCVR_SDR_BPB   = RCVR_DATA_W / 8;
  localparam int RCVR_DDR_BPB   = (2 * RCVR_DATA_W) / 8;
  localparam int RCVR_DLP_TMO   = 64;
  localparam int RCVR_MAX_RETRY = 3;

  // DDR moves data on both clock edges, so one beat carries twice the bytes.
  function automatic int beat_bytes(input int data_w, input logic ddr);
    int bytes;
    if (ddr) begin
      bytes = (2 * data_w) / 8;
    end else begin
      bytes = data_w / 8;
    end
    return bytes;
  endfunction

endpackage

// File: rtl/rcvr_seq_fsm_if.sv
// -----------------------------------------------------------------------------
// rcvr_seq_fsm_if
// Bundle between the instruction handler / rx blocks (master) and the receive
// sequencer (slave).
//   master drives : read_instrn, ddr_en, instrn_dlp_en, dummy_cycles, rd_len,
//                   dlp_read_stop, rx_beat_valid, csr_read_end
//   slave drives  : rxdata_blk_en, training_blk_en, rx_byte_cnt, rd_done,
//                   rd_abort, dlp_err, busy
// -----------------------------------------------------------------------------
interface rcvr_seq_fsm_if #(
  parameter int LEN_W   = 16,
  parameter int DUMMY_W = 5
);

  logic               read_instrn;
  logic               ddr_en;
  logic               instrn_dlp_en;
  logic [DUMMY_W-1:0] dummy_cycles;
  logic [LEN_W-1:0]   rd_len;
  logic               dlp_read_stop;
  logic               rx_beat_valid;
  logic               csr_read_end;

  logic               rxdata_blk_en;
  logic               training_blk_en;
  logic [LEN_W-1:0]   rx_byte_cnt;
  logic               rd_done;
  logic               rd_abort;
  logic               dlp_err;
  logic               busy;

  modport master (
    output read_instrn, ddr_en, instrn_dlp_en, dummy_cycles, rd_len,
           dlp_read_stop, rx_beat_valid, csr_read_end,
    input  rxdata_blk_en, training_blk_en, rx_byte_cnt, rd_done,
           rd_abort, dlp_err, busy
  );

  modport slave (
    input  read_instrn, ddr_en, instrn_dlp_en, dummy_cycles, rd_len,
           dlp_read_stop, rx_beat_valid, csr_read_end,
    output rxdata_blk_en, training_blk_en, rx_byte_cnt, rd_done,
           rd_abort, dlp_err, busy
  );

endinterface

// File: rtl/rcvr_byte_ctr.sv
// -----------------------------------------------------------------------------
// rcvr_byte_ctr
// Saturating received-byte counter with last-beat detection.
//   mem_clk, reset : clock, synchronous active-high reset
//   clear          : zero the count (start of a read)
//   beat           : one qualified data beat this cycle
//   ddr            : selects DDR bytes-per-beat
//   len            : latched read length in bytes (saturation point)
//   cnt            : registered byte count
//   last           : this beat reaches len (combinational)
// -----------------------------------------------------------------------------
module rcvr_byte_ctr
  import rcvr_pkg::*;
#(
  parameter int LEN_W   = 16,
  parameter int SDR_BPB = RCVR_SDR_BPB,
  parameter int DDR_BPB = RCVR_DDR_BPB
) (
  input  logic             mem_clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             beat,
  input  logic             ddr,
  input  logic [LEN_W-1:0] len,
  output logic [LEN_W-1:0] cnt,
  output logic             last
);

  localparam int CW = LEN_W + 1;
  localparam logic [LEN_W:0] SDR_INC = CW'(SDR_BPB);
  localparam logic [LEN_W:0] DDR_INC = CW'(DDR_BPB);

  logic [LEN_W-1:0] cnt_r;
  logic [LEN_W:0]   sum_s;

  // Count after one more beat; one bit wider so a near-full count cannot wrap.
  always_comb begin
    if (ddr) begin
      sum_s = {1'b0, cnt_r} + DDR_INC;
    end else begin
      sum_s = {1'b0, cnt_r} + SDR_INC;
    end
  end

  // A partial final DDR beat overshoots len and still counts as last.
  assign last = beat && (sum_s >= {1'b0, len});

  // Byte count register, clamped to len on the last beat.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (last) begin
      cnt_r <= len;
    end else if (beat) begin
      cnt_r <= sum_s[LEN_W-1:0];
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;

endmodule

// File: rtl/rcvr_seq_fsm.sv
// -----------------------------------------------------------------------------
// rcvr_seq_fsm
// Receive-path sequencer: IDLE -> [DUMMY] -> [DLP] -> RD_DATA -> IDLE.
// Enables the training monitor during DLP and the rxdata block during data
// capture, counts received bytes, and pulses rd_done / rd_abort / dlp_err.
//   mem_clk : clock
//   reset   : synchronous active-high reset
//   bus     : rcvr_seq_fsm_if slave modport (start/config, DLP stop, beats,
//             abort in; enables, byte count, status pulses, busy out)
// Build option RCVR_DLP_RETRY_EN: a DLP timeout retries training (1-cycle
// training gap) up to MAX_RETRY times before reporting dlp_err.
// -----------------------------------------------------------------------------
module rcvr_seq_fsm
  import rcvr_pkg::*;
#(
  parameter int DATA_W    = RCVR_DATA_W,
  parameter int LEN_W     = 16,
  parameter int DUMMY_W   = 5,
  parameter int DLP_TMO   = RCVR_DLP_TMO,
  parameter int MAX_RETRY = RCVR_MAX_RETRY
) (
  input logic           mem_clk,
  input logic           reset,
  rcvr_seq_fsm_if.slave bus
);

  localparam logic [1:0] S_IDLE    = ST_IDLE;
  localparam logic [1:0] S_DUMMY   = ST_DUMMY;
  localparam logic [1:0] S_DLP     = ST_DLP;
  localparam logic [1:0] S_RD_DATA = ST_RD_DATA;

  localparam int TMO_W   = (DLP_TMO > 2) ? $clog2(DLP_TMO) : 1;
  localparam int RETRY_W = (MAX_RETRY > 1) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(DLP_TMO - 1);

  logic [1:0]         state_r;
  logic               ddr_r;
  logic               dlp_en_r;
  logic [LEN_W-1:0]   len_r;
  logic [DUMMY_W-1:0] dummy_cnt_r;
  logic [TMO_W-1:0]   tmo_cnt_r;
  logic [RETRY_W-1:0] retry_cnt_r;
  logic               dlp_gap_r;
  logic               rx_en_r;
  logic               trn_en_r;
  logic               done_r;
  logic               abort_r;
  logic               err_r;
  logic               busy_r;

  logic [1:0]         state_nxt_s;
  logic [DUMMY_W-1:0] dummy_nxt_s;
  logic [TMO_W-1:0]   tmo_nxt_s;
  logic [RETRY_W-1:0] retry_nxt_s;
  logic               gap_nxt_s;
  logic               done_nxt_s;
  logic               abort_nxt_s;
  logic               err_nxt_s;
  logic               start_s;
  logic               retry_ok_s;
  logic               beat_s;
  logic               last_s;
  logic [LEN_W-1:0]   byte_cnt_s;

`ifdef RCVR_DLP_RETRY_EN
  assign retry_ok_s = (retry_cnt_r < RETRY_W'(MAX_RETRY));
`else
  assign retry_ok_s = 1'b0;
`endif

  // An abort in the same cycle discards the beat, so the count never moves
  // on an aborted cycle.
  assign beat_s = (state_r == S_RD_DATA) && bus.rx_beat_valid && !bus.csr_read_end;

  rcvr_byte_ctr #(
    .LEN_W   (LEN_W),
    .SDR_BPB (beat_bytes(DATA_W, 1'b0)),
    .DDR_BPB (beat_bytes(DATA_W, 1'b1))
  ) u_byte_ctr (
    .mem_clk (mem_clk),
    .reset   (reset),
    .clear   (start_s),
    .beat    (beat_s),
    .ddr     (ddr_r),
    .len     (len_r),
    .cnt     (byte_cnt_s),
    .last    (last_s)
  );

  // Next-state and next-output decode; abort outranks every other exit.
  always_comb begin
    state_nxt_s = state_r;
    dummy_nxt_s = dummy_cnt_r;
    tmo_nxt_s   = '0;
    retry_nxt_s = retry_cnt_r;
    gap_nxt_s   = 1'b0;
    done_nxt_s  = 1'b0;
    abort_nxt_s = 1'b0;
    err_nxt_s   = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.read_instrn && !bus.csr_read_end) begin
          start_s     = 1'b1;
          dummy_nxt_s = bus.dummy_cycles;
          retry_nxt_s = '0;
          if (bus.rd_len == '0) begin
            done_nxt_s = 1'b1;
          end else if (bus.dummy_cycles != '0) begin
            state_nxt_s = S_DUMMY;
          end else if (bus.instrn_dlp_en) begin
            state_nxt_s = S_DLP;
          end else begin
            state_nxt_s = S_RD_DATA;
          end
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_DUMMY: begin
        if (bus.csr_read_end) begin
          state_nxt_s = S_IDLE;
          abort_nxt_s = 1'b1;
        end else if (dummy_cnt_r == DUMMY_W'(1)) begin
          state_nxt_s = dlp_en_r ? S_DLP : S_RD_DATA;
        end else begin
          dummy_nxt_s = dummy_cnt_r - DUMMY_W'(1);
        end
      end
      S_DLP: begin
        if (bus.csr_read_end) begin
          state_nxt_s = S_IDLE;
          abort_nxt_s = 1'b1;
        end else if (bus.dlp_read_stop) begin
          state_nxt_s = S_RD_DATA;
        end else if (tmo_cnt_r == TMO_LAST) begin
          if (retry_ok_s) begin
            // Stay in DLP with training dropped for one cycle, counter at 0.
            gap_nxt_s   = 1'b1;
            retry_nxt_s = retry_cnt_r + RETRY_W'(1);
          end else begin
            state_nxt_s = S_IDLE;
            err_nxt_s   = 1'b1;
          end
        end else if (dlp_gap_r) begin
          tmo_nxt_s = '0;
        end else begin
          tmo_nxt_s = tmo_cnt_r + TMO_W'(1);
        end
      end
      S_RD_DATA: begin
        if (bus.csr_read_end) begin
          state_nxt_s = S_IDLE;
          abort_nxt_s = 1'b1;
        end else if (last_s) begin
          state_nxt_s = S_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = S_RD_DATA;
        end
      end
      default: begin
        state_nxt_s = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs (enables follow the next state).
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      state_r     <= S_IDLE;
      dummy_cnt_r <= '0;
      tmo_cnt_r   <= '0;
      retry_cnt_r <= '0;
      dlp_gap_r   <= 1'b0;
      rx_en_r     <= 1'b0;
      trn_en_r    <= 1'b0;
      done_r      <= 1'b0;
      abort_r     <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      dummy_cnt_r <= dummy_nxt_s;
      tmo_cnt_r   <= tmo_nxt_s;
      retry_cnt_r <= retry_nxt_s;
      dlp_gap_r   <= gap_nxt_s;
      rx_en_r     <= (state_nxt_s == S_RD_DATA);
      trn_en_r    <= (state_nxt_s == S_DLP) && !gap_nxt_s;
      done_r      <= done_nxt_s;
      abort_r     <= abort_nxt_s;
      err_r       <= err_nxt_s;
      busy_r      <= (state_nxt_s != S_IDLE);
    end
  end

  // Read configuration captured at start and held for the whole read.
  always_ff @(posedge mem_clk) begin
    if (reset) begin
      ddr_r    <= 1'b0;
      dlp_en_r <= 1'b0;
      len_r    <= '0;
    end else if (start_s) begin
      ddr_r    <= bus.ddr_en;
      dlp_en_r <= bus.instrn_dlp_en;
      len_r    <= bus.rd_len;
    end else begin
      ddr_r    <= ddr_r;
      dlp_en_r <= dlp_en_r;
      len_r    <= len_r;
    end
  end

  assign bus.rxdata_blk_en   = rx_en_r;
  assign bus.training_blk_en = trn_en_r;
  assign bus.rx_byte_cnt     = byte_cnt_s;
  assign bus.rd_done         = done_r;
  assign bus.rd_abort        = abort_r;
  assign bus.dlp_err         = err_r;
  assign bus.busy            = busy_r;

endmodule
